pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_stall_ctrl_wait_watchdog.sv | 45 ++++
 rtl/pipe_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall FSM state encoding and watchdog default.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } stall_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_wait_state(input stall_state_e st);
    return (st == MEM_WAIT) || (st == MD_WAIT);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_wait_watchdog.sv
// Wait-state residency counter with a sticky timeout flag; expire fires on the
// TIMEOUT-th consecutive cycle spent in the same wait state.
module wait_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  input  logic state_change,
  output logic expire,
  output logic wd_timeout
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt_reg;
  logic [15:0] wait_cnt_next;
  logic        wd_reg;
  logic        wd_next;

  assign expire     = in_wait && (wait_cnt_reg == LIMIT);
  assign wd_timeout = wd_reg;

  // Expiry always forces a state change, so the counter never passes LIMIT.
  always_comb begin
    wait_cnt_next = '0;
    wd_next       = wd_reg | expire;
    if (in_wait && !state_change) begin
      wait_cnt_next = wait_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      wd_reg       <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      wd_reg       <= wd_next;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: mem wait, mul/div
// wait, redirect and load-use, with a stall-cycle counter and wait watchdog.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             modify_pc_ex,
  input  logic             ex_muldiv,
  input  logic             muldiv_done,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wd_timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stall_state_e     state_reg;
  stall_state_e     state_next;
  logic             md_seen_reg;
  logic             md_seen_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             mem_stall;
  logic             md_stall;
  logic             wd_expire;

  // Bit order: [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb
  logic [4:0] en_c;
  logic [4:0] en_port;
  // Bit order: [0]=if_id, [1]=id_ex, [2]=ex_mem, [3]=mem_wb
  logic [3:0] flush_c;
  logic [3:0] flush_port;

  always_comb begin
    en_c       = 5'b11111;
    flush_c    = 4'b0000;
    state_next = RUN;
    mem_stall  = (state_reg == MEM_WAIT) ? !dmem_ready : (mem_req && !dmem_ready);
    md_stall   = !mem_stall && ex_muldiv && !muldiv_done && !md_seen_reg;

    if (mem_stall) begin
      en_c       = 5'b00000;
      flush_c    = 4'b1000;
      state_next = MEM_WAIT;
    end else if (md_stall) begin
      en_c       = 5'b11000;
      flush_c    = 4'b0100;
      state_next = MD_WAIT;
    end else if (modify_pc_ex) begin
      flush_c = 4'b0011;
    end else if (load_use_hazard) begin
      en_c    = 5'b11000;
      flush_c = 4'b0010;
    end

    // A stuck wait is broken by one pass through RUN; the request re-stalls if still present.
    if (wd_expire) begin
      state_next = RUN;
    end
  end

  // A done pulse swallowed by a mem freeze must not re-trigger a mul/div wait.
  always_comb begin
    md_seen_next = md_seen_reg;
    if (mem_stall && muldiv_done) begin
      md_seen_next = 1'b1;
    end else if (en_c[3]) begin
      md_seen_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      md_seen_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      md_seen_reg <= md_seen_next;
      if (!en_c[0]) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
    end
  end

  wait_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_wait     (is_wait_state(state_reg)),
    .state_change(state_next != state_reg),
    .expire      (wd_expire),
    .wd_timeout  (wd_timeout)
  );

  // Controls read as reset values while reset is held, whatever the requests.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_en
      assign en_port[gi] = en_c[gi] | ~rst_n;
    end
    for (gi = 0; gi < 4; gi++) begin : g_flush
      assign flush_port[gi] = flush_c[gi] & rst_n;
    end
  endgenerate

  assign pc_en        = en_port[0];
  assign if_id_en     = en_port[1];
  assign id_ex_en     = en_port[2];
  assign ex_mem_en    = en_port[3];
  assign mem_wb_en    = en_port[4];
  assign if_id_flush  = flush_port[0];
  assign id_ex_flush  = flush_port[1];
  assign ex_mem_flush = flush_port[2];
  assign mem_wb_flush = flush_port[3];
  assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios then random traffic,
// checked every cycle against a behavioural model of the stall rules.
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 32;

  bit   clk;
  logic rst_n;
  logic load_use_hazard, modify_pc_ex, ex_muldiv, muldiv_done, mem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic wd_timeout;

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_hazard(load_use_hazard), .modify_pc_ex(modify_pc_ex),
    .ex_muldiv(ex_muldiv), .muldiv_done(muldiv_done),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cnt(stall_cnt), .wd_timeout(wd_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       en;   // {mem_wb, ex_mem, id_ex, if_id, pc}
    logic [3:0]       fl;   // {mem_wb, ex_mem, id_ex, if_id}
    logic [CNT_W-1:0] cnt;
    logic             wd;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Model: which unit is being waited on (0 none, 1 memory, 2 mul/div) and for how long.
  int               m_kind;
  int               m_waited;
  bit               m_md_seen;
  bit               m_wd;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_step();
    exp_t e;
    bit   frz_mem, frz_md;
    int   nk;
    e.en  = 5'b11111;
    e.fl  = 4'b0000;
    e.cnt = m_cnt;
    e.wd  = m_wd;
    if (!rst_n) begin
      m_kind = 0; m_waited = 0; m_md_seen = 0; m_wd = 0; m_cnt = '0;
      e.cnt = '0;
      e.wd  = 1'b0;
    end else begin
      // While waiting on memory only its readiness matters; otherwise a new request must be pending.
      frz_mem = (m_kind == 1) ? !dmem_ready : (mem_req && !dmem_ready);
      frz_md  = !frz_mem && ex_muldiv && !muldiv_done && !m_md_seen;
      if (frz_mem) begin
        e.en = 5'b00000; e.fl = 4'b1000;
      end else if (frz_md) begin
        e.en = 5'b11000; e.fl = 4'b0100;
      end else if (modify_pc_ex) begin
        e.fl = 4'b0011;
      end else if (load_use_hazard) begin
        e.en = 5'b11000; e.fl = 4'b0010;
      end
      if (!e.en[0]) m_cnt = m_cnt + 1;
      if (frz_mem && muldiv_done) m_md_seen = 1;
      else if (e.en[3]) m_md_seen = 0;
      nk = frz_mem ? 1 : (frz_md ? 2 : 0);
      if (m_kind != 0 && m_waited + 1 == TIMEOUT) begin
        m_wd = 1;
        nk   = 0;
      end
      m_waited = (m_kind != 0 && nk == m_kind) ? m_waited + 1 : 0;
      m_kind   = nk;
    end
    q.push_back(e);
  endtask

  // One clock cycle of stimulus: drive just after the edge, predict, enqueue.
  task automatic cyc(input bit rn, input bit lu, input bit mpc, input bit exm,
                     input bit mdd, input bit mr, input bit dr);
    @(posedge clk);
    #1;
    rst_n = rn; load_use_hazard = lu; modify_pc_ex = mpc; ex_muldiv = exm;
    muldiv_done = mdd; mem_req = mr; dmem_ready = dr;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a.en  = {mem_wb_en, ex_mem_en, id_ex_en, if_id_en, pc_en};
      a.fl  = {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush};
      a.cnt = stall_cnt;
      a.wd  = wd_timeout;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctrl txn=%0d got en=%b fl=%b cnt=%0d wd=%b expected en=%b fl=%b cnt=%0d wd=%b",
                 txn, a.en, a.fl, a.cnt, a.wd, e.en, e.fl, e.cnt, e.wd);
      end else begin
        $display("txn %0d en=%b fl=%b cnt=%0d wd=%b ok", txn, a.en, a.fl, a.cnt, a.wd);
      end
      txn++;
    end
  end

  initial begin
    rst_n = 0; load_use_hazard = 0; modify_pc_ex = 0; ex_muldiv = 0;
    muldiv_done = 0; mem_req = 0; dmem_ready = 1;
    m_kind = 0; m_waited = 0; m_md_seen = 0; m_wd = 0; m_cnt = '0;

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    idle(10);
    // load-use for one cycle
    cyc(1, 1, 0, 0, 0, 0, 1);
    idle(2);
    // mem wait of 3 with a redirect held throughout, then release
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 1);
    idle(2);
    // mul/div with done in cycle 5
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 1, 0, 1);
    idle(2);
    // done pulse swallowed by a mem stall
    cyc(1, 0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 1, 1, 0);
    cyc(1, 0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 1, 1);
    idle(2);
    // watchdog: memory never ready
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
    idle(2);
    // reset in the middle of a wait, requests still asserted
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 700; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 35));
    end
    idle(2);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
